// File: rtl/ram_if.sv
// Request/response bus between a memory requester and ram_responder.
interface ram_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (output ramREN, ramWEN, ramaddr, ramstore, input ramload, ramstate);
  modport slave  (input ramREN, ramWEN, ramaddr, ramstore, output ramload, ramstate);
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM model with fixed access latency LAT and a FREE/BUSY/ACCESS/ERROR handshake.
// Define RAM_ADDR_CHECK_EN to flag addresses beyond DEPTH*4 as ERROR instead of wrapping.
module ram_responder #(
  parameter int LAT   = 2,
  parameter int DEPTH = 1024
) (
  input logic  CLK,
  input logic  nRST,
  ram_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:2] lat_addr;
  logic        lat_wr;
  logic [31:0] lat_data;
  logic [31:0] load_q;
  logic [31:0] mem [DEPTH];

  logic          req_valid, req_err, changed, latch, commit;
  logic [1:0]    rstate;
  logic [AW-1:0] idx;
  logic          unused_lsb;

  assign unused_lsb = ^bus.ramaddr[1:0];
  assign req_valid  = bus.ramREN ^ bus.ramWEN;
  assign idx        = lat_addr[AW+1:2];
  assign changed    = (bus.ramaddr[31:2] != lat_addr) || (bus.ramWEN != lat_wr) ||
                      (bus.ramstore != lat_data);

`ifdef RAM_ADDR_CHECK_EN
  assign req_err = (bus.ramREN & bus.ramWEN) | (req_valid & (|bus.ramaddr[31:AW+2]));
`else
  assign req_err = bus.ramREN & bus.ramWEN;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    commit  = 1'b0;
    rstate  = FREE;
    if (req_err) begin
      state_n = IDLE;
      cnt_n   = '0;
      rstate  = ERROR;
    end else begin
      unique case (state)
        IDLE: if (req_valid) latch = 1'b1;
        WAIT: begin
          rstate = BUSY;
          if (!req_valid) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (changed) begin
            latch = 1'b1;
          end else if (cnt <= 4'd1) begin
            state_n = DONE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 4'd1;
          end
        end
        DONE: begin
          // A request that moved during ACCESS is a new access, not a completion
          if (req_valid && changed) begin
            latch = 1'b1;
          end else begin
            rstate  = ACCESS;
            commit  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      if (latch) begin
        rstate  = BUSY;
        cnt_n   = CNT_INIT;
        state_n = (LAT == 1) ? DONE : WAIT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_wr   <= 1'b0;
      lat_data <= '0;
      load_q   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        lat_addr <= bus.ramaddr[31:2];
        lat_wr   <= bus.ramWEN;
        lat_data <= bus.ramstore;
      end
      if (commit && !lat_wr) load_q <= mem[idx];
    end
  end

  // Storage is deliberately outside the reset domain
  always_ff @(posedge CLK) begin
    if (commit && lat_wr) mem[idx] <= lat_data;
  end

  assign bus.ramload  = (commit && !lat_wr) ? mem[idx] : load_q;
  assign bus.ramstate = nRST ? rstate : FREE;
endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: LAT=1/2/3 instances share one stimulus bus selected by sel.
module tb_ram_responder;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  typedef struct {
    bit          rst, r, w;
    logic [31:0] a, d;
    bit          cs;
    logic [1:0]  st;
    bit          cl;
    logic [31:0] ld;
  } cyc_t;

  logic        CLK = 1'b0, nRST = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [31:0] addr = '0, data = '0;
  int          sel = 2;
  logic [1:0]  ost;
  logic [31:0] old;
  int          n_vec = 0, n_err = 0;
  cyc_t        sb[$];

  ram_if b1 ();
  ram_if b2 ();
  ram_if b3 ();

  ram_responder #(.LAT(1), .DEPTH(1024)) u1 (.CLK(CLK), .nRST(nRST), .bus(b1));
  ram_responder #(.LAT(2), .DEPTH(1024)) u2 (.CLK(CLK), .nRST(nRST), .bus(b2));
  ram_responder #(.LAT(3), .DEPTH(1024)) u3 (.CLK(CLK), .nRST(nRST), .bus(b3));

  always #5 CLK = ~CLK;

  assign b1.ramREN = ren & (sel == 1);
  assign b1.ramWEN = wen & (sel == 1);
  assign b2.ramREN = ren & (sel == 2);
  assign b2.ramWEN = wen & (sel == 2);
  assign b3.ramREN = ren & (sel == 3);
  assign b3.ramWEN = wen & (sel == 3);
  assign b1.ramaddr = addr;  assign b1.ramstore = data;
  assign b2.ramaddr = addr;  assign b2.ramstore = data;
  assign b3.ramaddr = addr;  assign b3.ramstore = data;

  always_comb begin
    ost = b2.ramstate;
    old = b2.ramload;
    case (sel)
      1: begin ost = b1.ramstate; old = b1.ramload; end
      3: begin ost = b3.ramstate; old = b3.ramload; end
      default: ;
    endcase
  end

  function automatic cyc_t C(bit r, bit w, logic [31:0] a, logic [31:0] d, bit cs,
                             logic [1:0] st, bit cl, logic [31:0] ld, bit rst = 1'b0);
    cyc_t c;
    c.rst = rst; c.r = r; c.w = w; c.a = a; c.d = d;
    c.cs = cs; c.st = st; c.cl = cl; c.ld = ld;
    return c;
  endfunction

  task automatic drive(input cyc_t c);
    ren = c.r; wen = c.w; addr = c.a; data = c.d; nRST = ~c.rst;
  endtask

  task automatic test_reset();
    nRST = 1'b0; ren = 1'b1; addr = 32'h40;
    for (int s = 1; s <= 3; s++) begin
      sel = s;
      @(negedge CLK);
      n_vec++;
      if (ost !== FREE || old !== 32'h0) begin
        n_err++;
        $display("FAIL reset lat%0d: state=%0d load=%h expected state=0 load=0", s, ost, old);
      end
      @(posedge CLK); #1;
    end
    ren = 1'b0; nRST = 1'b1; sel = 2;
  endtask

  task automatic test_write_read();
    cyc_t v[$]; cyc_t e;
    sel = 2;
    repeat (2) v.push_back(C(0,1,32'h40,32'hDEADBEEF,1,BUSY,0,0));
    v.push_back(C(0,1,32'h40,32'hDEADBEEF,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0));
    repeat (2) v.push_back(C(1,0,32'h40,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h40,0,1,ACCESS,1,32'hDEADBEEF));
    v.push_back(C(0,0,0,0,1,FREE,1,32'hDEADBEEF));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL write_read step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_error();
    cyc_t v[$]; cyc_t e;
    sel = 2;
    repeat (2) v.push_back(C(0,1,32'h20,32'h11112222,1,BUSY,0,0));
    v.push_back(C(0,1,32'h20,32'h11112222,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'hDEADBEEF));
    v.push_back(C(0,1,32'h20,32'h5555,1,BUSY,0,0));
    repeat (2) v.push_back(C(1,1,32'h20,32'h1234,1,ERROR,1,32'hDEADBEEF));
    v.push_back(C(0,0,0,0,1,FREE,1,32'hDEADBEEF));
    repeat (2) v.push_back(C(1,0,32'h20,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h20,0,1,ACCESS,1,32'h11112222));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h11112222));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL error step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_drop();
    cyc_t v[$]; cyc_t e;
    sel = 2;
    repeat (2) v.push_back(C(0,1,32'h24,32'hAAAA0001,1,BUSY,0,0));
    v.push_back(C(0,1,32'h24,32'hAAAA0001,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h11112222));
    v.push_back(C(0,1,32'h24,32'hBBBB0002,1,BUSY,0,0));
    v.push_back(C(0,0,0,0,0,FREE,1,32'h11112222));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h11112222));
    repeat (2) v.push_back(C(1,0,32'h24,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h24,0,1,ACCESS,1,32'hAAAA0001));
    v.push_back(C(0,0,0,0,1,FREE,1,32'hAAAA0001));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL drop step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t v[$]; cyc_t e;
    sel = 2;
    repeat (2) v.push_back(C(0,1,32'h8,32'h0BAD0008,1,BUSY,0,0));
    v.push_back(C(0,1,32'h8,32'h0BAD0008,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'hAAAA0001));
    v.push_back(C(0,1,32'h8,32'hCAFEF00D,1,BUSY,0,0));
    v.push_back(C(0,1,32'h8,32'hCAFEF00D,1,FREE,1,32'h0,1'b1));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0));
    repeat (2) v.push_back(C(1,0,32'h8,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h8,0,1,ACCESS,1,32'h0BAD0008));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0BAD0008));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL reset_mid step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_addr_range();
    cyc_t v[$]; cyc_t e;
    sel = 2;
    repeat (2) v.push_back(C(0,1,32'h0,32'h00000AAA,1,BUSY,0,0));
    v.push_back(C(0,1,32'h0,32'h00000AAA,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0BAD0008));
`ifdef RAM_ADDR_CHECK_EN
    repeat (3) v.push_back(C(0,1,32'h1000,32'h5A5A5A5A,1,ERROR,1,32'h0BAD0008));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0BAD0008));
    repeat (2) v.push_back(C(1,0,32'h0,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h0,0,1,ACCESS,1,32'h00000AAA));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h00000AAA));
`else
    repeat (2) v.push_back(C(0,1,32'h1000,32'h5A5A5A5A,1,BUSY,0,0));
    v.push_back(C(0,1,32'h1000,32'h5A5A5A5A,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0BAD0008));
    repeat (2) v.push_back(C(1,0,32'h0,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h0,0,1,ACCESS,1,32'h5A5A5A5A));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h5A5A5A5A));
`endif
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL addr_range step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_restart();
    cyc_t v[$]; cyc_t e;
    sel = 3;
    repeat (3) v.push_back(C(0,1,32'h10,32'h10101010,1,BUSY,0,0));
    v.push_back(C(0,1,32'h10,32'h10101010,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0));
    repeat (3) v.push_back(C(0,1,32'h14,32'h14141414,1,BUSY,0,0));
    v.push_back(C(0,1,32'h14,32'h14141414,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0));
    v.push_back(C(1,0,32'h10,0,1,BUSY,0,0));
    repeat (3) v.push_back(C(1,0,32'h14,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h14,0,1,ACCESS,1,32'h14141414));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h14141414));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL restart step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t v[$]; cyc_t e;
    sel = 1;
    v.push_back(C(0,1,32'h0,32'hA0A0A0A0,1,BUSY,0,0));
    v.push_back(C(0,1,32'h0,32'hA0A0A0A0,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0));
    v.push_back(C(0,1,32'h4,32'hB4B4B4B4,1,BUSY,0,0));
    v.push_back(C(0,1,32'h4,32'hB4B4B4B4,1,ACCESS,0,0));
    v.push_back(C(0,0,0,0,1,FREE,1,32'h0));
    v.push_back(C(1,0,32'h0,0,1,BUSY,0,0));
    v.push_back(C(1,0,32'h0,0,1,ACCESS,1,32'hA0A0A0A0));
    v.push_back(C(1,0,32'h4,0,1,BUSY,1,32'hA0A0A0A0));
    v.push_back(C(1,0,32'h4,0,1,ACCESS,1,32'hB4B4B4B4));
    v.push_back(C(0,0,0,0,1,FREE,1,32'hB4B4B4B4));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(negedge CLK);
      e = sb.pop_front(); n_vec++;
      if ((e.cs && ost !== e.st) || (e.cl && old !== e.ld)) begin
        n_err++;
        $display("FAIL back_to_back step %0d: state=%0d load=%h expected state=%0d load=%h", i, ost, old, e.st, e.ld);
      end
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_error();
    test_drop();
    test_reset_mid();
    test_addr_range();
    test_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
